// File: rtl/tx_gearbox_66b32b.sv
// rtl/tx_gearbox_66b32b.sv - 66b-to-32b transmit gearbox between 64b/66b encoder and PMA
//
// Purpose: packs 66-bit blocks (sync header + two 32-bit words) into a continuous
// serial-ordered 32-bit stream. Bit 0 of o_data is transmitted first. One input
// pause cycle is inserted every 33 cycles (16 blocks = 33 output words).
//
// Ports:
//   i_clk    - clock
//   i_reset  - asynchronous active-high reset
//   i_data   - encoded word; first word = block bits [33:2], second = [65:34]
//   i_hdr    - sync header, sampled only with the first word of a block
//   i_valid  - i_data (and i_hdr on the first word) valid
//   o_ready  - input accepted this cycle when high; low one cycle per 33
//   o_data   - serial-ordered output word
//   o_valid  - o_data valid
//   o_err    - only with TX_GEARBOX_ERR_EN: one-cycle pulse on invalid header
//              or on i_valid while o_ready is low
//
// Optional feature macro: TX_GEARBOX_ERR_EN
module tx_gearbox_66b32b #(
    parameter int DATA_WIDTH = 32,
    parameter int HDR_WIDTH  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [HDR_WIDTH-1:0]  i_hdr,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid
`ifdef TX_GEARBOX_ERR_EN
    ,
    output logic                  o_err
`endif
);

    localparam int         BUF_W     = 96;
    localparam logic [5:0] PAUSE_CNT = 6'd32;

    generate
        if (DATA_WIDTH != 32 || HDR_WIDTH != 2) begin : g_bad_params
            $error("tx_gearbox_66b32b supports only DATA_WIDTH=32 and HDR_WIDTH=2");
        end
    endgenerate

    logic [BUF_W-1:0]      buf_q, buf_d;
    logic [6:0]            fill_q, fill_d;
    logic [5:0]            seq_cnt_q, seq_cnt_d;
    logic                  word_phase_q, word_phase_d;
    logic [DATA_WIDTH-1:0] o_data_q, o_data_d;
    logic                  o_valid_q, o_valid_d;

    logic                  accept;
    logic [33:0]           app_bits;
    logic [6:0]            app_len;
    logic [6:0]            total;
    logic [BUF_W-1:0]      merged;

    assign o_ready = (seq_cnt_q != PAUSE_CNT);
    assign o_data  = o_data_q;
    assign o_valid = o_valid_q;

    always_comb begin
        accept   = i_valid && (seq_cnt_q != PAUSE_CNT);
        app_bits = '0;
        app_len  = '0;
        if (accept) begin
            if (word_phase_q) begin
                app_bits = {2'b00, i_data};
                app_len  = 7'd32;
            end else begin
                // Header goes first on the wire, so it sits in the low bits.
                app_bits = {i_data, i_hdr};
                app_len  = 7'd34;
            end
        end

        // Bits above fill_q are always zero, so OR-ing in the new bits appends them.
        merged = buf_q | ({{(BUF_W-34){1'b0}}, app_bits} << fill_q);
        total  = fill_q + app_len;

        if (total >= 7'd32) begin
            o_data_d  = merged[31:0];
            buf_d     = {32'b0, merged[BUF_W-1:32]};
            fill_d    = total - 7'd32;
            o_valid_d = 1'b1;
        end else begin
            o_data_d  = o_data_q;
            buf_d     = merged;
            fill_d    = total;
            o_valid_d = 1'b0;
        end

        // The pause cycle always advances the sequence; otherwise only accepts do,
        // so an idle source never shifts where the pause lands.
        if (seq_cnt_q == PAUSE_CNT) begin
            seq_cnt_d = 6'd0;
        end else if (accept) begin
            seq_cnt_d = seq_cnt_q + 6'd1;
        end else begin
            seq_cnt_d = seq_cnt_q;
        end

        word_phase_d = word_phase_q ^ accept;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            buf_q        <= '0;
            fill_q       <= '0;
            seq_cnt_q    <= '0;
            word_phase_q <= 1'b0;
            o_data_q     <= '0;
            o_valid_q    <= 1'b0;
        end else begin
            buf_q        <= buf_d;
            fill_q       <= fill_d;
            seq_cnt_q    <= seq_cnt_d;
            word_phase_q <= word_phase_d;
            o_data_q     <= o_data_d;
            o_valid_q    <= o_valid_d;
        end
    end

`ifdef TX_GEARBOX_ERR_EN
    logic o_err_q, o_err_d;

    assign o_err = o_err_q;

    always_comb begin
        o_err_d = (accept && !word_phase_q && (i_hdr == 2'b00 || i_hdr == 2'b11))
                || (i_valid && !o_ready);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_err_q <= 1'b0;
        end else begin
            o_err_q <= o_err_d;
        end
    end
`endif

endmodule

// File: tb/tb_tx_gearbox_66b32b.sv
// tb/tb_tx_gearbox_66b32b.sv - directed self-checking bench for tx_gearbox_66b32b
module tb_tx_gearbox_66b32b;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_data;
    logic [1:0]  i_hdr;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] o_data;
    logic        o_valid;
`ifdef TX_GEARBOX_ERR_EN
    logic        o_err;
`endif

    int           errors = 0;
    int           checks = 0;
    bit           ref_bits[$];
    logic [31:0]  out_q[$];
    int           err_pulses = 0;
    logic [255:0] vhist;

    always #5 clk = ~clk;

    tx_gearbox_66b32b dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_data  (i_data),
        .i_hdr   (i_hdr),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_valid (o_valid)
`ifdef TX_GEARBOX_ERR_EN
        ,
        .o_err   (o_err)
`endif
    );

    always @(negedge clk) begin
        if (!rst && o_valid) out_q.push_back(o_data);
`ifdef TX_GEARBOX_ERR_EN
        if (!rst && o_err) err_pulses++;
`endif
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        i_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic logic [1:0] blk_hdr(input int b);
        return b[0] ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [31:0] blk_w0(input int b);
        logic [31:0] bb;
        bb = b[31:0];
        return 32'h9E3779B9 * (bb + 32'd1);
    endfunction

    function automatic logic [31:0] blk_w1(input int b);
        logic [31:0] bb;
        bb = b[31:0];
        return (32'h85EBCA6B * (bb + 32'd3)) ^ 32'h5A5A0FF0;
    endfunction

    task automatic push_word(input logic [31:0] d, input logic [1:0] h, input bit first);
        if (first) begin
            ref_bits.push_back(h[0]);
            ref_bits.push_back(h[1]);
        end
        for (int j = 0; j < 32; j++) ref_bits.push_back(d[j]);
    endtask

    // Drives nblk blocks; stall_len idle cycles are inserted before word index stall_at.
    task automatic drive(input int nblk, input int stall_at, input int stall_len,
                         output int nlow, output int low_at);
        int wi;
        int cyc;
        int stalls;
        int b;
        wi = 0; cyc = 0; stalls = 0;
        nlow = 0; low_at = -1; vhist = '0;
        while (wi < 2 * nblk && cyc < 250) begin
            b = wi / 2;
            if (wi == stall_at && stalls < stall_len) begin
                i_valid = 1'b0;
                stalls++;
            end else begin
                i_valid = 1'b1;
                i_hdr   = blk_hdr(b);
                i_data  = wi[0] ? blk_w1(b) : blk_w0(b);
            end
            if (!o_ready) begin
                nlow++;
                low_at = cyc;
            end
            if (i_valid && o_ready) begin
                push_word(i_data, i_hdr, !wi[0]);
                wi++;
            end
            step();
            vhist[cyc] = o_valid;
            cyc++;
        end
        i_valid = 1'b0;
        check("drive_done", wi, 2 * nblk);
    endtask

    task automatic check_stream(input string tag, input int obase, input int rbase, input int nwords);
        logic [31:0] exp;
        check({tag, "_word_count"}, out_q.size() - obase, nwords);
        for (int k = 0; k < nwords; k++) begin
            if (obase + k < out_q.size() && rbase + 32 * k + 31 < ref_bits.size()) begin
                for (int j = 0; j < 32; j++) exp[j] = ref_bits[rbase + 32 * k + j];
                check($sformatf("%s_word%0d", tag, k), out_q[obase + k], exp);
            end
        end
    endtask

    int nlow, low_at, obase, rbase, ebase;

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_data = '0; i_hdr = '0;
        step();
        step();
        check("rst_o_valid", o_valid, 0);
        check("rst_o_ready", o_ready, 1);
        check("rst_o_data", o_data, 0);
        rst = 1'b0;

        // Single hand-computed block
        i_valid = 1'b1; i_hdr = 2'b01; i_data = 32'hDEADBEEF;
        step();
        check("blk_w0_data", o_data, 32'h7AB6FBBD);
        check("blk_w0_valid", o_valid, 1);
        i_data = 32'h12345678;
        step();
        check("blk_w1_data", o_data, 32'h48D159E3);
        check("blk_w1_valid", o_valid, 1);
        i_valid = 1'b0;
        step();
        check("blk_idle_valid", o_valid, 0);
        check("blk_idle_hold", o_data, 32'h48D159E3);

        // 17 back-to-back blocks; input held valid across the pause
        do_reset();
        obase = out_q.size(); rbase = ref_bits.size(); ebase = err_pulses;
        drive(17, -1, 0, nlow, low_at);
        check("cont_ready_lows", nlow, 1);
        check("cont_pause_pos", low_at, 32);
        check("cont_valid_run", vhist[34:0], {35{1'b1}});
        step();
        check("cont_tail_valid", o_valid, 0);
        check_stream("cont", obase, rbase, 35);
`ifdef TX_GEARBOX_ERR_EN
        check("cont_err_pulses", err_pulses - ebase, 1);
`endif

        // 16 blocks with a 3-cycle stall between word0 and word1 of the first block
        do_reset();
        obase = out_q.size(); rbase = ref_bits.size();
        drive(16, 1, 3, nlow, low_at);
        check("stall_ready_lows", nlow, 0);
        check("stall_valid_pattern", vhist[4:0], 5'b10001);
        check("stall_pause_ready", o_ready, 0);
        step();
        check("stall_pause_valid", o_valid, 1);
        check("stall_after_ready", o_ready, 1);
        step();
        check("stall_drain_valid", o_valid, 0);
        check_stream("stall", obase, rbase, 33);

        // Reset after word0 discards the partial block
        do_reset();
        i_valid = 1'b1; i_hdr = 2'b10; i_data = 32'hCAFEF00D;
        step();
        check("rstmid_w0_valid", o_valid, 1);
        rst = 1'b1; i_valid = 1'b0;
        #1;
        check("rstmid_valid", o_valid, 0);
        check("rstmid_ready", o_ready, 1);
        check("rstmid_data", o_data, 0);
        step();
        rst = 1'b0;
        i_valid = 1'b1; i_hdr = 2'b10; i_data = 32'h0F0F0F0F;
        step();
        check("rstmid_hdr_word", o_data, 32'h3C3C3C3E);
        i_data = 32'hA5A5A5A5;
        step();
        check("rstmid_w1_word", o_data, 32'h96969694);
        i_valid = 1'b0;
        step();

`ifdef TX_GEARBOX_ERR_EN
        do_reset();
        i_valid = 1'b1; i_hdr = 2'b11; i_data = 32'hDEADBEEF;
        step();
        check("err_bad_hdr", o_err, 1);
        check("err_bad_hdr_data", o_data, 32'h7AB6FBBF);
        i_data = 32'h12345678;
        step();
        check("err_clear", o_err, 0);
        i_hdr = 2'b10; i_data = 32'hDEADBEEF;
        step();
        check("err_good_hdr", o_err, 0);
        i_data = 32'h12345678;
        step();
        check("err_good_w1", o_err, 0);
        i_valid = 1'b0;
        step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tx_gearbox_66b32b.md
Name: tx_gearbox_66b32b

Overview:
- Transmit-side 66b-to-32b gearbox. It sits between the 64b/66b encoder and the SerDes/PMA, and is the counterpart of the receive block-sync path.
- Input: 66-bit blocks presented as two 32-bit words, with the 2-bit sync header attached to the first word.
- Output: a continuous 32-bit/cycle serial-ordered stream.
- Throughput matching: one input pause cycle every 33 cycles (16 blocks = 1056 bits = 33 output words).

Parameters:
- DATA_WIDTH, 32, data word width; only 32 is supported, and elaboration fails otherwise.
- HDR_WIDTH, 2, sync header width; only 2 is supported.

Ports:
- i_clk  input  1  single clock domain
- i_reset  input  1  asynchronous, active-high reset
- i_data  input  DATA_WIDTH  encoded data word; first word = block bits [33:2], second = [65:34]
- i_hdr  input  HDR_WIDTH  sync header; sampled only on the first word of a block
- i_valid  input  1  i_data (and i_hdr on first word) valid
- o_ready  output  1  gearbox accepts input this cycle; low for exactly one cycle per 33-cycle sequence
- o_data  output  DATA_WIDTH  serial-ordered output word; bit 0 transmitted first
- o_valid  output  1  o_data valid

Behaviour:
- Reset (async assert, sync release): o_data=0, o_valid=0, o_ready=1, seq_cnt=0, fill=0, word_phase=0 (expect first word), buffer cleared.
- Bit order per block: i_hdr[0], i_hdr[1], word0[0..31], word1[0..31]. Earlier bits occupy lower o_data bits.
- Accept condition: i_valid && o_ready.
  - word_phase=0: append {i_data, i_hdr} (34 bits) at buffer position fill.
  - word_phase=1: append i_data (32 bits).
  - word_phase toggles on each accept.
- Output: each cycle, if (fill + bits appended this cycle) >= 32, the lowest 32 buffered bits are registered to o_data, o_valid=1, and the remainder shifts down. Otherwise o_valid=0 and o_data holds its value.
- Latency: 1 cycle, from accepted input to o_data containing its lowest bits.
- fill arithmetic:
  - Net change per accepted word: +34-32 or +32-32.
  - Net change per pause cycle: -32.
  - Steady-state range 0..32 after output; internal buffer width 96 bits, so fill never exceeds 66.
- Sequence counter seq_cnt (0..32):
  - Increments on accept or on the pause cycle.
  - o_ready = (seq_cnt != 32).
  - seq_cnt==32 is the pause cycle: no input is accepted, one word is drained from the buffer, and seq_cnt wraps to 0.
- Stall (i_valid=0 while o_ready=1): seq_cnt and word_phase hold. Output is produced only if fill >= 32, otherwise o_valid=0. No bits are lost or duplicated.
- i_valid=1 during the pause cycle: the input is ignored (not accepted); the source must hold it.
- Steady state with continuous i_valid: o_valid=1 every cycle after the first accept, and fill returns to 0 after each pause.
- Reset mid-block: the partial block is discarded, and the next accept is treated as word0.

Optional Feature:
TX_GEARBOX_ERR_EN
- Defined: adds output o_err (1 bit, reset 0), a registered one-cycle pulse on either of:
  - an accepted word0 with i_hdr of 2'b00 or 2'b11;
  - i_valid=1 while o_ready=0.
  Data handling is unchanged.
- Undefined: the o_err port and its logic are absent; invalid headers pass through unchecked.

Test Plan:
- Reset then single block: hdr=2'b01, w0=32'hDEADBEEF, w1=32'h12345678 -> cycle+1 o_data=32'h7AB6FBBD ({w0[29:0],01}), o_valid=1; next o_data={w1[29:0],w0[31:30]}=32'h48D159E3.
- 16 back-to-back random blocks with continuous i_valid -> o_ready low exactly on cycle 32 after the first accept, o_valid high 33 consecutive cycles, and the reassembled bitstream equals the concatenated reference blocks bit-for-bit.
- Insert i_valid=0 for 3 cycles between word0 and word1 -> seq_cnt frozen, o_valid drops when fill<32, and the bitstream is still identical to the no-stall reference.
- Hold i_valid=1 across the pause cycle -> that word is not consumed and is accepted on the following cycle; no bit duplication. With TX_GEARBOX_ERR_EN, o_err pulses once.
- Assert i_reset after word0 of a block -> o_valid=0, o_ready=1, fill=0 immediately; the next accepted word is treated as a header word.
- With TX_GEARBOX_ERR_EN, send hdr=2'b11 -> o_err=1 for exactly one cycle and data still passes through; hdr=2'b10 -> o_err stays 0.
